// File: rtl/uart_receive.sv
`default_nettype none
// ============================================================================
//  Module   : uart_receive
//  Purpose  : 8N1 UART receiver. Synchronises the asynchronous serial line,
//             recovers start/data/stop framing at BAUD_DIVIDE+1 clocks per
//             bit and queues good bytes in a small circular FIFO. Framing
//             errors and FIFO overruns are reported through sticky flags.
//  Ports    : clk           - single clock
//             reset_n       - asynchronous assert, active-low reset
//             uart_rx       - serial input, idle high, asynchronous to clk
//             rx_char       - FIFO head byte (8'h00 when empty)
//             rx_char_valid - FIFO not empty
//             rx_read       - pop the FIFO head (ignored when empty)
//             frame_error   - sticky: a stop bit was sampled low
//             overrun       - sticky: a good byte was dropped, FIFO full
//             clear_errors  - clears both sticky flags
//  Revision : 1.0 - initial release
// ============================================================================
module uart_receive #(
    parameter int BAUD_DIVIDE = 1,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rx,
    output logic [7:0] rx_char,
    output logic       rx_char_valid,
    input  logic       rx_read,
    output logic       frame_error,
    output logic       overrun,
    input  logic       clear_errors
);

    localparam int c_TW = (BAUD_DIVIDE > 1) ? $clog2(BAUD_DIVIDE + 1) : 1;
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;

    localparam logic [c_TW-1:0] c_BIT_RELOAD  = c_TW'(BAUD_DIVIDE);
    localparam logic [c_TW-1:0] c_HALF_RELOAD = c_TW'(BAUD_DIVIDE / 2);
    localparam logic [c_TW-1:0] c_TIMER_ONE   = c_TW'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE     = c_AW'(1);
    localparam logic [c_CW-1:0] c_CNT_ONE     = c_CW'(1);
    localparam logic [c_CW-1:0] c_FULL_COUNT  = c_CW'(FIFO_DEPTH);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_BREAK = 3'd4;

    // ------------------------------------------------------------------
    // Two-flop synchroniser; both stages reset to the idle (high) level
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Frame recovery FSM
    // ------------------------------------------------------------------
    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_TW-1:0] r_timer;
    logic [c_TW-1:0] w_timer_nxt;
    logic [2:0]      r_bit_cnt;
    logic [2:0]      w_bit_cnt_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic            w_sample;
    logic            w_push_req;
    logic            w_ferr_set;

    assign w_sample = (r_timer == '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_push_req    = 1'b0;
        w_ferr_set    = 1'b0;

        // The bit timer free-runs only while a frame is in progress
        if ((r_state == c_ST_START) || (r_state == c_ST_DATA) || (r_state == c_ST_STOP)) begin
            w_timer_nxt = w_sample ? c_BIT_RELOAD : (r_timer - c_TIMER_ONE);
        end

        case (r_state)
            c_ST_IDLE: begin
                // Half-bit load centres every following sample in its bit
                if (!r_rx_s) begin
                    w_timer_nxt = c_HALF_RELOAD;
                    w_state_nxt = c_ST_START;
                end
            end
            c_ST_START: begin
                if (w_sample) begin
                    if (!r_rx_s) begin
                        w_state_nxt   = c_ST_DATA;
                        w_bit_cnt_nxt = 3'd0;
                    end else begin
                        w_state_nxt   = c_ST_IDLE;
                    end
                end
            end
            c_ST_DATA: begin
                if (w_sample) begin
                    w_shift_nxt = {r_rx_s, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = c_ST_STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            c_ST_STOP: begin
                if (w_sample) begin
                    w_push_req  = r_rx_s;
                    w_ferr_set  = ~r_rx_s;
                    w_state_nxt = r_rx_s ? c_ST_IDLE : c_ST_BREAK;
                end
            end
            c_ST_BREAK: begin
                // A held-low line must return high before a new frame is armed
                if (r_rx_s) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_ST_IDLE;
            r_timer   <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_ovr_set;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL_COUNT);
    assign w_pop     = rx_read & ~w_empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands
    assign w_push    = w_push_req & (~w_full | w_pop);
    assign w_ovr_set = w_push_req & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rx_char_valid = ~w_empty;
    assign rx_char       = w_empty ? 8'h00 : r_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // Sticky error flags: a set in the same cycle beats a clear
    // ------------------------------------------------------------------
    logic r_frame_error;
    logic r_overrun;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_ferr_set) begin
                r_frame_error <= 1'b1;
            end else if (clear_errors) begin
                r_frame_error <= 1'b0;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (clear_errors) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: doc/uart_receive.md
# uart_receive

Serial receive side of the FPGA UART: samples an asynchronous `uart_rx` line, recovers 8N1 frames (start bit, 8 data bits LSB first, stop bit) and queues received bytes in a small FIFO for the host-side register interface. It uses the same `BAUD_DIVIDE` convention as the UART transmitter, so a paired transmitter/receiver with equal parameters interoperate. It reports framing errors and FIFO overruns through sticky flags.

## Interface
- `BAUD_DIVIDE`, 1 — bit period is `BAUD_DIVIDE+1` clocks, same as the transmitter; legal range ≥ 3.
- `FIFO_DEPTH`, 8 — receive FIFO entries; power of two, ≥ 2.
- `clk` in 1 — the single clock.
- `reset_n` in 1 — asynchronous assert, active-low reset.
- `uart_rx` in 1 — serial input, asynchronous to `clk`, idle high.
- `rx_char` out 8 — FIFO head byte; reads 8'h00 when FIFO empty.
- `rx_char_valid` out 1 — FIFO not empty.
- `rx_read` in 1 — pops the head when `rx_char_valid`=1; ignored when empty.
- `frame_error` out 1 — sticky; a stop bit was sampled low.
- `overrun` out 1 — sticky; a good byte arrived with the FIFO full.
- `clear_errors` in 1 — clears both sticky flags.

## Operation
- Input synchronizer: two flops on `uart_rx`, both reset to 1. All logic uses the synchronized value `rx_s`.
- Bit timer: a down-counter, 32 bits or sized to `BAUD_DIVIDE`. A sample event occurs when the counter is 0. On each sample the counter reloads to `BAUD_DIVIDE`, giving P = `BAUD_DIVIDE+1` clocks between samples.
- State machine:
  - IDLE: when `rx_s`=0, load counter with `BAUD_DIVIDE/2` (integer divide) and go to START.
  - START: at sample, if `rx_s`=0 go to DATA with bit count 0. If `rx_s`=1 (glitch), return to IDLE silently.
  - DATA: at each sample, shift `rx_s` into bit[7] of the shift register, shifting right. After the 8th sample go to STOP.
  - STOP:
    - At sample with `rx_s`=1, push the byte, or set `overrun` and drop the byte if the FIFO is full. Go to IDLE.
    - At sample with `rx_s`=0, set `frame_error`, drop the byte and go to BREAK.
  - BREAK: wait until `rx_s`=1, then go to IDLE. This prevents a held-low line from retriggering.
- FIFO: circular buffer with read and write pointers plus a count, or pointers carrying an extra wrap bit; pointers wrap modulo `FIFO_DEPTH`.
  - Push and pop in the same cycle on a non-empty FIFO: both take effect and the count is unchanged.
  - Push while full with `rx_read`=1 in the same cycle: the pop frees an entry, so the push succeeds and no overrun is flagged.
  - Push into an empty FIFO with `rx_read`=1: the pop is ignored and the byte is stored.
- Sticky flags: set takes priority over `clear_errors` in the same cycle.
- Reset, asynchronous at any point including mid-frame:
  - state returns to IDLE, counters 0, FIFO empty;
  - `rx_char`=0, `rx_char_valid`=0, `frame_error`=0, `overrun`=0;
  - synchronizer flops return to 1.

## Timing
- Falling edge on `uart_rx` reaches `rx_s` 2 clocks later. IDLE detects it in that cycle.
- Start sample: `BAUD_DIVIDE/2 + 1` clocks after detection, i.e. mid start bit. Each data and stop sample follows P clocks after the previous one.
- The stop sample lands in cycle T. `rx_char_valid`, `rx_char`, `frame_error` and `overrun` update at the edge ending T and are visible in T+1.
- A pop takes effect at the edge ending the `rx_read` cycle. The next head byte, or `rx_char_valid`=0, is visible in the following cycle.
- Back-to-back frames are supported: a new start edge detected in IDLE immediately after the stop sample is received correctly, with no idle gap needed beyond the stop bit's second half.

## Test plan
All scenarios use `BAUD_DIVIDE`=15 (P=16 clocks) and `FIFO_DEPTH`=8.
- Single frame 0x55, ideal timing → `rx_char_valid`=1 and `rx_char`=0x55 at stop sample +1. Pulse `rx_read` → `rx_char_valid`=0 and `rx_char`=0x00. No flags set.
- Low glitch of 4 clocks on idle line → no byte queued, state back to IDLE, flags 0. A following 0xA7 frame is received correctly.
- Frame 0xA3 with stop bit low, line then held low 40 clocks, then high, then frame 0x12 → `frame_error`=1, FIFO holds only 0x12. `clear_errors` → `frame_error`=0.
- Nine back-to-back frames 0x00..0x08 with no reads → `overrun`=1, reads return 0x00..0x07 in order, then `rx_char_valid`=0. Assert `clear_errors` in the same cycle as a new overrun → flag stays 1.
- FIFO full, `rx_read`=1 during the ninth frame's stop-sample cycle → no overrun, FIFO still holds 8 entries. Reads return 0x01..0x08.
- `reset_n` low for 3 clocks during data bit 4 of a frame → all outputs 0 immediately. After release, the next frame 0xC3 is received correctly.
- Random clock skew of ±3% on the transmitted bit period over 200 random bytes → all bytes received, no flags.
